stage_memory_lsu: RTL

//  Parametrised memory pipeline stage (MEM) between execute and writeback.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/lsu_align.sv | 60 ++++++
 rtl/stage_memory_lsu.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared load/store encodings, LSU state type and the funct3 size decoder.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {IDLE, WAIT} lsu_state_e;

    typedef struct packed {
        logic       legal;
        logic       isUnsigned;
        logic [1:0] sizeLog2;
    } size_dec_t;

    // Doubleword and unsigned-word encodings exist only on RV64.
    function automatic size_dec_t decodeSize(input logic [2:0] funct3,
                                             input logic       isStore,
                                             input logic       isRv64);
        size_dec_t d;
        d.sizeLog2   = funct3[1:0];
        d.isUnsigned = funct3[2];
        if (isStore)
            d.legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                      (isRv64 && funct3 == F3_D);
        else
            d.legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                      (funct3 == F3_BU) || (funct3 == F3_HU) ||
                      (isRv64 && (funct3 == F3_D || funct3 == F3_WU));
        return d;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, replicated store data, load extract/extend, fault flag.
module lsu_align
    import riscv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]       funct3,
    input  logic             isStore,
    input  logic [OFF_W-1:0] addrLow,
    input  logic [XLEN-1:0]  storeData,
    input  logic [XLEN-1:0]  loadWord,
    output logic [NB-1:0]    byteEn,
    output logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  loadData,
    output logic             fault
);

    size_dec_t       dec;
    logic [3:0]      sizeM1;
    logic [NB-1:0]   laneMask;
    logic [XLEN-1:0] shifted;
    logic            signBit;

    always_comb begin
        dec      = decodeSize(funct3, isStore, XLEN == 64);
        sizeM1   = (4'd1 << dec.sizeLog2) - 4'd1;
        fault    = !dec.legal || ((addrLow & OFF_W'(sizeM1)) != '0);

        laneMask = '0;
        for (int i = 0; i < NB; i++)
            if (i <= int'(sizeM1)) laneMask[i] = 1'b1;
        byteEn = (isStore && !fault) ? (laneMask << addrLow) : '0;

        // Each lane carries the store byte it would hold at any aligned offset.
        wdata = '0;
        for (int i = 0; i < NB; i++) begin
            unique case (dec.sizeLog2)
                2'd0:    wdata[8*i +: 8] = storeData[7:0];
                2'd1:    wdata[8*i +: 8] = storeData[8*(i%2) +: 8];
                2'd2:    wdata[8*i +: 8] = storeData[8*(i%4) +: 8];
                default: wdata[8*i +: 8] = storeData[8*(i%8) +: 8];
            endcase
        end

        shifted = loadWord >> {addrLow, 3'b000};
        unique case (dec.sizeLog2)
            2'd0:    signBit = shifted[7];
            2'd1:    signBit = shifted[15];
            2'd2:    signBit = shifted[31];
            default: signBit = shifted[XLEN-1];
        endcase
        signBit  = signBit && !dec.isUnsigned;
        loadData = shifted;
        for (int i = 0; i < XLEN; i++)
            if (i >= (8 << dec.sizeLog2)) loadData[i] = signBit;
    end

endmodule

// File: rtl/stage_memory_lsu.sv
// MEM pipeline stage: issues one load/store at a time on a req/ack port, else passes through.
module stage_memory_lsu
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Valid,
    output logic                 o_Ready,
    input  logic                 i_MemRead,
    input  logic                 i_MemWrite,
    input  logic [2:0]           i_Funct3,
    input  logic [XLEN-1:0]      i_AluOutput,
    input  logic [XLEN-1:0]      i_Reg2Value,
    input  logic                 i_RegWrite,
    input  logic [REG_IDX_W-1:0] i_Rd,
    output logic                 o_DmemReq,
    output logic                 o_DmemWe,
    output logic [ADDR_W-1:0]    o_DmemAddr,
    output logic [XLEN-1:0]      o_DmemWdata,
    output logic [XLEN/8-1:0]    o_DmemByteEn,
    input  logic                 i_DmemAck,
    input  logic [XLEN-1:0]      i_DmemRdata,
    output logic                 o_Valid,
    output logic                 o_RegWrite,
    output logic [REG_IDX_W-1:0] o_Rd,
    output logic [XLEN-1:0]      o_AluOutput,
    output logic [XLEN-1:0]      o_MemoryData,
    output logic                 o_MisalignedFault
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e state, stateNext;

    logic [2:0]           pendFunct3;
    logic [OFF_W-1:0]     pendAddrLow;
    logic                 pendLoad;
    logic                 pendRegWrite;
    logic [REG_IDX_W-1:0] pendRd;
    logic [XLEN-1:0]      pendAlu;

    logic             accept, isMem, ack, issue;
    logic [2:0]       alignFunct3;
    logic             alignStore;
    logic [OFF_W-1:0] alignAddrLow;
    logic [NB-1:0]    byteEn;
    logic [XLEN-1:0]  wdata, loadData;
    logic             fault;

    assign o_Ready = (state == IDLE);
    assign accept  = i_Valid && o_Ready;
    assign isMem   = i_MemRead || i_MemWrite;
    assign ack     = (state == WAIT) && o_DmemReq && i_DmemAck;
    assign issue   = accept && isMem && !fault;

    // One align unit serves both the issue decision (live inputs) and the load return (held op).
    assign alignFunct3  = o_Ready ? i_Funct3 : pendFunct3;
    assign alignStore   = o_Ready ? i_MemWrite : 1'b0;
    assign alignAddrLow = o_Ready ? i_AluOutput[OFF_W-1:0] : pendAddrLow;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3    (alignFunct3),
        .isStore   (alignStore),
        .addrLow   (alignAddrLow),
        .storeData (i_Reg2Value),
        .loadWord  (i_DmemRdata),
        .byteEn    (byteEn),
        .wdata     (wdata),
        .loadData  (loadData),
        .fault     (fault)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (issue) stateNext = WAIT;
            WAIT: if (ack)   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_DmemReq         <= 1'b0;
            o_DmemWe          <= 1'b0;
            o_DmemAddr        <= '0;
            o_DmemWdata       <= '0;
            o_DmemByteEn      <= '0;
            pendFunct3        <= '0;
            pendAddrLow       <= '0;
            pendLoad          <= 1'b0;
            pendRegWrite      <= 1'b0;
            pendRd            <= '0;
            pendAlu           <= '0;
            o_Valid           <= 1'b0;
            o_RegWrite        <= 1'b0;
            o_Rd              <= '0;
            o_AluOutput       <= '0;
            o_MemoryData      <= '0;
            o_MisalignedFault <= 1'b0;
        end else begin
            o_Valid <= 1'b0;
            if (issue) begin
                o_DmemReq    <= 1'b1;
                o_DmemWe     <= i_MemWrite;
                o_DmemAddr   <= i_AluOutput[ADDR_W-1:0] & ~ADDR_W'(NB - 1);
                o_DmemWdata  <= wdata;
                o_DmemByteEn <= byteEn;
                pendFunct3   <= i_Funct3;
                pendAddrLow  <= i_AluOutput[OFF_W-1:0];
                pendLoad     <= !i_MemWrite;
                pendRegWrite <= i_RegWrite && !i_MemWrite;
                pendRd       <= i_Rd;
                pendAlu      <= i_AluOutput;
            end else if (accept) begin
                // Pass-through or faulting access: retire immediately without touching memory.
                o_Valid           <= 1'b1;
                o_RegWrite        <= i_RegWrite && !isMem;
                o_Rd              <= i_Rd;
                o_AluOutput       <= i_AluOutput;
                o_MemoryData      <= '0;
                o_MisalignedFault <= isMem;
            end else if (ack) begin
                o_DmemReq         <= 1'b0;
                o_Valid           <= 1'b1;
                o_RegWrite        <= pendRegWrite;
                o_Rd              <= pendRd;
                o_AluOutput       <= pendAlu;
                o_MemoryData      <= pendLoad ? loadData : '0;
                o_MisalignedFault <= 1'b0;
            end
        end
    end

endmodule
